// File: rtl/netflow_export_record_fifo.sv
// netflow_export_record_fifo
//   Purpose : synchronous FIFO for expired-flow export records. It has a
//             first-word-fall-through valid/ready output, a programmable
//             almost-full threshold, an occupancy level, a saturating drop
//             counter and a high-water mark. Storage is an inferred RAM plus
//             one output register.
//   Latency : a write into an empty FIFO at edge N is presented on rd_data
//             with rd_valid=1 after edge N+2.
//   Backpres: the writer throttles on almost_full/full. Writes made while
//             full are dropped and counted. The reader stalls through
//             rd_ready, and rd_data holds while rd_valid & !rd_ready.
// Ports:
//   ACLK, ARESETN          clock (rising edge), async active-low reset
//   flush                  synchronous clear of contents (hwm/drop_count kept)
//   wr_en, wr_data         write strobe and record
//   full, almost_full      registered occupancy flags
//   rd_valid, rd_ready     FWFT handshake; pop = rd_valid & rd_ready
//   rd_data                oldest record
//   level                  records held, including the output register
//   hwm                    maximum level since reset
//   drop_count             writes discarded while full, saturating

module netflow_export_record_fifo #(
  parameter int unsigned REC_W     = 240,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned AF_MARGIN = 128,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [REC_W-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [REC_W-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] hwm,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(DEPTH - AF_MARGIN);

  // Record storage. It has no reset, because contents are undefined after
  // reset or flush.
  logic [REC_W-1:0] mem [DEPTH];

  // Pointers carry one wrap bit above the address bits.
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  // One-cycle-delayed copy of the write pointer, as seen by the read side.
  // A word written at edge N becomes readable only at edge N+2. This keeps
  // the read away from a RAM location written in the same cycle, and it
  // produces the documented two-edge fall-through latency.
  logic [PTR_W-1:0] wr_vis_q, wr_vis_d;

  logic             rd_valid_q, rd_valid_d;
  logic [REC_W-1:0] rd_data_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic [LVL_W-1:0] hwm_q, hwm_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic pop;
  logic wr_acc;
  logic wr_drop;
  logic ram_ne;
  logic refill;

  assign pop     = rd_valid_q & rd_ready & ~flush;
  assign wr_acc  = wr_en & ~full_q & ~flush;
  // full_q is the registered flag, so a write that arrives in the same
  // cycle as a pop at full is still dropped.
  assign wr_drop = wr_en & full_q & ~flush;
  assign ram_ne  = (wr_vis_q != rd_ptr_q);
  // The output register takes the next RAM word when it is empty or is
  // being emptied this cycle.
  assign refill  = (~rd_valid_q | pop) & ram_ne & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_vis_d   = wr_ptr_q;
    rd_valid_d = rd_valid_q;
    level_d    = level_q;
    drop_d     = drop_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      wr_vis_d   = '0;
      rd_valid_d = 1'b0;
      level_d    = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (refill) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        rd_valid_d = 1'b1;
      end else if (pop) begin
        rd_valid_d = 1'b0;
      end
      case ({wr_acc, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
      if (wr_drop && (drop_q != {CNT_W{1'b1}})) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end

    full_d = (level_d == FULL_LVL);
    af_d   = (level_d >= AF_LVL);
    hwm_d  = (level_d > hwm_q) ? level_d : hwm_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_vis_q   <= '0;
      rd_valid_q <= 1'b0;
      level_q    <= '0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      hwm_q      <= '0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_vis_q   <= wr_vis_d;
      rd_valid_q <= rd_valid_d;
      level_q    <= level_d;
      full_q     <= full_d;
      af_q       <= af_d;
      hwm_q      <= hwm_d;
      drop_q     <= drop_d;
    end
  end

  // FWFT output register. It is loaded straight from the RAM read port.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_data_q <= '0;
    end else if (refill) begin
      rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_acc) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  assign full        = full_q;
  assign almost_full = af_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign level       = level_q;
  assign hwm         = hwm_q;
  assign drop_count  = drop_q;

endmodule
